// File: rtl/ofdm_cp_inserter.sv
// Cyclic-prefix inserter for the OFDM transmit chain: captures one IFFT frame from
// myFFT, then replays it as CP_LEN prefix samples followed by the NFFT-sample body.
module ofdm_cp_inserter #(
    parameter int unsigned SIZE_BUFFER = 8,
    parameter int unsigned DATA_SIZE   = 16,
    parameter int unsigned CP_LEN      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fft_complete,
    input  logic [DATA_SIZE-1:0] data_in_i,
    input  logic [DATA_SIZE-1:0] data_in_q,
    output logic                 flag_ready_recive,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_i,
    output logic [DATA_SIZE-1:0] out_q,
    output logic                 out_first,
    output logic                 out_last,
    output logic [1:0]           state,
    output logic                 drop_err
);
    localparam int unsigned NFFT = 1 << SIZE_BUFFER;
    localparam int unsigned WORD = 2 * DATA_SIZE;
    localparam logic [SIZE_BUFFER-1:0] LAST_IDX = SIZE_BUFFER'(NFFT - 1);
    localparam logic [SIZE_BUFFER-1:0] CP_START = SIZE_BUFFER'(NFFT - CP_LEN);

    if (CP_LEN < 1 || CP_LEN >= NFFT) begin : g_cp_len_check
        $error("ofdm_cp_inserter: CP_LEN must lie in 1..NFFT-1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CP   = 2'd2,
        S_BODY = 2'd3
    } state_t;

    state_t cur, nxt;

    logic [WORD-1:0]        mem [NFFT];
    logic [SIZE_BUFFER-1:0] wr_addr;
    logic [SIZE_BUFFER-1:0] rd_addr;
    logic [SIZE_BUFFER-1:0] rd_next;
    logic [WORD-1:0]        in_word;
    logic [WORD-1:0]        start_word;
    logic                   rdy;
    logic                   accept;
    logic                   handshake;
    logic                   load_en;
    logic                   start_frame;
    logic                   take_next;
    logic                   end_sym;

    assign in_word = {data_in_i, data_in_q};
    assign rd_next = rd_addr + SIZE_BUFFER'(1);
    assign load_en = !out_valid || out_ready;

    // With CP_LEN == 1 the first prefix sample is the one being written this edge.
    assign start_word = (CP_START == LAST_IDX) ? in_word : mem[CP_START];

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt         = cur;
        rdy         = 1'b0;
        accept      = 1'b0;
        handshake   = 1'b0;
        start_frame = 1'b0;
        take_next   = 1'b0;
        end_sym     = 1'b0;

        rdy       = (cur == S_IDLE) || (cur == S_LOAD);
        accept    = fft_complete && rdy;
        handshake = out_valid && out_ready;

        unique case (cur)
            S_IDLE: begin
                if (accept) begin
                    nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && wr_addr == LAST_IDX) begin
                    nxt         = S_CP;
                    start_frame = 1'b1;
                end
            end
            S_CP: begin
                if (handshake) begin
                    take_next = 1'b1;
                    if (rd_addr == LAST_IDX) begin
                        nxt = S_BODY;
                    end
                end
            end
            S_BODY: begin
                if (handshake) begin
                    if (rd_addr == LAST_IDX) begin
                        nxt     = S_IDLE;
                        end_sym = 1'b1;
                    end else begin
                        take_next = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= in_word;
        end
    end

    // rd_addr always names the buffer index currently held in the output register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_addr   <= '0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_i     <= '0;
            out_q     <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            if (accept) begin
                wr_addr <= wr_addr + SIZE_BUFFER'(1);
            end
            if (fft_complete && !rdy) begin
                drop_err <= 1'b1;
            end
            if (load_en) begin
                if (start_frame) begin
                    out_valid      <= 1'b1;
                    {out_i, out_q} <= start_word;
                    out_first      <= 1'b1;
                    out_last       <= 1'b0;
                    rd_addr        <= CP_START;
                end else if (take_next) begin
                    {out_i, out_q} <= mem[rd_next];
                    out_first      <= 1'b0;
                    out_last       <= (cur == S_BODY) && (rd_next == LAST_IDX);
                    rd_addr        <= rd_next;
                end else if (end_sym) begin
                    out_valid <= 1'b0;
                    out_first <= 1'b0;
                    out_last  <= 1'b0;
                    rd_addr   <= '0;
                end
            end
        end
    end

    assign flag_ready_recive = rdy;
    assign state             = cur;

endmodule

// File: tb/tb_ofdm_cp_inserter.sv
// Directed scoreboard bench for ofdm_cp_inserter: a small (NFFT=16, CP=4) instance
// and a default (NFFT=256, CP=64) instance.
module tb_ofdm_cp_inserter;
    logic clk = 1'b0;
    logic reset;

    logic        a_cmp, a_flag, a_valid, a_ready, a_first, a_last, a_drop;
    logic [15:0] a_i, a_q, a_oi, a_oq;
    logic [1:0]  a_state;

    logic        b_cmp, b_flag, b_valid, b_ready, b_first, b_last, b_drop;
    logic [15:0] b_i, b_q, b_oi, b_oq;
    logic [1:0]  b_state;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_a     = 0;
    int hs_b     = 0;
    int hs0;
    int sent;

    logic [33:0] qa[$];
    logic [33:0] qb[$];
    logic [33:0] a_exp, b_exp;
    logic        a_prev_stall = 1'b0;
    logic [34:0] a_prev_word  = '0;
    bit          b_seen_last  = 1'b0;
    int          b_hs_at_last1 = 0;
    time         b_last1_time = 0;
    time         b_acc2_time  = 0;

    ofdm_cp_inserter #(.SIZE_BUFFER(4), .DATA_SIZE(16), .CP_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .fft_complete(a_cmp),
        .data_in_i(a_i), .data_in_q(a_q), .flag_ready_recive(a_flag),
        .out_valid(a_valid), .out_ready(a_ready), .out_i(a_oi), .out_q(a_oq),
        .out_first(a_first), .out_last(a_last), .state(a_state), .drop_err(a_drop)
    );

    ofdm_cp_inserter #(.SIZE_BUFFER(8), .DATA_SIZE(16), .CP_LEN(64)) dut_b (
        .clk(clk), .reset(reset), .fft_complete(b_cmp),
        .data_in_i(b_i), .data_in_q(b_q), .flag_ready_recive(b_flag),
        .out_valid(b_valid), .out_ready(b_ready), .out_i(b_oi), .out_q(b_oq),
        .out_first(b_first), .out_last(b_last), .state(b_state), .drop_err(b_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected stream: prefix indices NFFT-CP..NFFT-1, then body 0..NFFT-1.
    task automatic push_frame(input int which, input int nfft, input int cp, input int base);
        int k;
        logic [33:0] w;
        for (int n = 0; n < cp + nfft; n++) begin
            k = (n < cp) ? nfft - cp + n : n - cp;
            w = {n == 0, n == cp + nfft - 1, 16'(base + k), 16'(0 - (base + k))};
            if (which == 0) qa.push_back(w);
            else            qb.push_back(w);
        end
    endtask

    task automatic send_a(input int base, input bit gap);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            a_cmp = 1'b1;
            a_i   = 16'(base + k);
            a_q   = 16'(0 - (base + k));
            if (gap && k != 15) begin
                @(posedge clk); #1;
                a_cmp = 1'b0;
                @(posedge clk);
            end
        end
        @(posedge clk); #1;
        a_cmp = 1'b0;
    endtask

    task automatic drain_a(input string tag, input int bound);
        for (int c = 0; c < bound && qa.size() != 0; c++) @(posedge clk);
        repeat (2) @(negedge clk);
        check(tag, 64'(qa.size()), 64'(0));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (a_prev_stall)
                check("a_hold", {a_valid, a_first, a_last, a_oi, a_oq}, a_prev_word);
            if (a_valid && a_ready) begin
                hs_a++;
                if (qa.size() == 0) begin
                    check("a_extra_out", 64'(qa.size()), 64'(1));
                end else begin
                    a_exp = qa.pop_front();
                    check("a_out", {a_first, a_last, a_oi, a_oq}, a_exp);
                end
            end
            a_prev_stall = a_valid && !a_ready;
            a_prev_word  = {a_valid, a_first, a_last, a_oi, a_oq};
        end else begin
            a_prev_stall = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset && b_valid && b_ready) begin
            hs_b++;
            if (qb.size() == 0) begin
                check("b_extra_out", 64'(qb.size()), 64'(1));
            end else begin
                b_exp = qb.pop_front();
                check("b_out", {b_first, b_last, b_oi, b_oq}, b_exp);
                if (b_exp[32] && !b_seen_last) begin
                    b_seen_last   = 1'b1;
                    b_hs_at_last1 = hs_b;
                    b_last1_time  = $time;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        a_cmp = 1'b0; a_i = '0; a_q = '0; a_ready = 1'b1;
        b_cmp = 1'b0; b_i = '0; b_q = '0; b_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", a_state, 0);
        check("rst_valid", a_valid, 0);
        check("rst_data", {a_oi, a_oq}, 0);
        check("rst_first_last", {a_first, a_last}, 0);
        check("rst_drop", a_drop, 0);
        check("rst_flag", a_flag, 1);
        check("rst_b_flag", b_flag, 1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Contiguous frame, out_ready high: 20 bubble-free cycles
        push_frame(0, 16, 4, 0);
        send_a(0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t1_valid_run", a_valid, 1);
            check("t1_flag_low", a_flag, 0);
        end
        @(negedge clk);
        check("t1_valid_drop", a_valid, 0);
        check("t1_flag_back", a_flag, 1);
        check("t1_idle", a_state, 0);
        drain_a("t1_drain", 10);

        // Gapped input: same output, no drop_err
        push_frame(0, 16, 4, 0);
        send_a(0, 1'b1);
        @(negedge clk);
        check("t2_cp_state", a_state, 2);
        drain_a("t2_drain", 100);
        check("t2_no_drop", a_drop, 0);

        // Backpressure: toggling ready plus a 5-cycle stall mid-BODY
        hs0 = hs_a;
        push_frame(0, 16, 4, 300);
        send_a(300, 1'b0);
        for (int c = 0; c < 300 && qa.size() != 0; c++) begin
            @(posedge clk); #1;
            a_ready = (c >= 16 && c < 21) ? 1'b0 : (c % 2 == 0);
        end
        a_ready = 1'b1;
        drain_a("t3_drain", 10);
        check("t3_handshakes", 64'(hs_a - hs0), 64'(20));

        // fft_complete asserted during CP sets sticky drop_err
        push_frame(0, 16, 4, 7);
        send_a(7, 1'b0);
        a_cmp = 1'b1; a_i = 16'hdead; a_q = 16'hbeef;
        @(negedge clk);
        check("t4_in_cp", a_state, 2);
        @(posedge clk); #1;
        a_cmp = 1'b0;
        @(negedge clk);
        check("t4_drop_set", a_drop, 1);
        drain_a("t4_drain", 100);
        check("t4_drop_sticky", a_drop, 1);

        // Reset mid-BODY, then a fresh frame
        hs0 = hs_a;
        push_frame(0, 16, 4, 50);
        send_a(50, 1'b0);
        for (int c = 0; c < 100 && hs_a < hs0 + 10; c++) @(posedge clk);
        #1;
        check("t5_mid_body", a_state, 3);
        reset = 1'b0;
        qa.delete();
        @(posedge clk);
        @(negedge clk);
        check("t5_state", a_state, 0);
        check("t5_valid", a_valid, 0);
        check("t5_flag", a_flag, 1);
        check("t5_drop", a_drop, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        push_frame(0, 16, 4, 200);
        send_a(200, 1'b0);
        drain_a("t5_fresh_drain", 100);

        // Default parameters: two back-to-back frames paced by flag_ready_recive
        hs0 = hs_b;
        push_frame(1, 256, 64, 0);
        push_frame(1, 256, 64, 1000);
        sent = 0;
        for (int c = 0; c < 4000 && sent < 512; c++) begin
            @(negedge clk);
            if (b_flag) begin
                b_cmp = 1'b1;
                b_i   = 16'((sent / 256) * 1000 + sent % 256);
                b_q   = 16'(0 - ((sent / 256) * 1000 + sent % 256));
                @(posedge clk);
                if (sent == 256) b_acc2_time = $time;
                sent++;
            end else begin
                b_cmp = 1'b0;
            end
        end
        @(negedge clk);
        b_cmp = 1'b0;
        for (int c = 0; c < 1000 && qb.size() != 0; c++) @(posedge clk);
        repeat (2) @(negedge clk);
        check("b_drain", 64'(qb.size()), 64'(0));
        check("b_sent", 64'(sent), 64'(512));
        check("b_symbol_len", 64'(b_hs_at_last1 - hs0), 64'(320));
        check("b_total", 64'(hs_b - hs0), 64'(640));
        check("b_frame2_after_last", {b_seen_last, b_acc2_time > b_last1_time}, 2'b11);
        check("b_no_drop", b_drop, 0);
        check("b_idle", b_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ofdm_cp_inserter.md
Name: ofdm_cp_inserter

Overview:
- Sits on the output side of myFFT in the OFDM transmit chain, after the inverse FFT.
- Answers myFFT's output handshake: drives flag_ready_recive and captures one NFFT-sample time-domain frame while complete is high.
- Replays the frame as CP_LEN cyclic-prefix samples followed by the full NFFT-sample body, on a valid/ready stream toward the DAC/framer.

Parameters:
- SIZE_BUFFER, 8, log2 of frame length; NFFT = 2**SIZE_BUFFER.
- DATA_SIZE, 16, width of each I and Q sample; input and output widths are equal.
- CP_LEN, 64, cyclic-prefix length in samples; legal range 1..NFFT-1; elaboration error outside that range.

Ports:
- clk, input, 1: single clock for everything.
- reset, input, 1: synchronous, active-low.
- fft_complete, input, 1: myFFT complete; high means data_in_i/q holds a valid output sample.
- data_in_i, input, DATA_SIZE: FFT output, I.
- data_in_q, input, DATA_SIZE: FFT output, Q.
- flag_ready_recive, output, 1: this block accepts FFT samples; drives myFFT.flag_ready_recive.
- out_valid, output, 1: out_i/out_q valid.
- out_ready, input, 1: downstream accepts.
- out_i, output, DATA_SIZE: output sample, I.
- out_q, output, DATA_SIZE: output sample, Q.
- out_first, output, 1: first CP sample of a symbol.
- out_last, output, 1: last body sample (index NFFT-1).
- state, output, 2: 0 IDLE, 1 LOAD, 2 CP, 3 BODY.
- drop_err, output, 1: sticky; a sample was presented while flag_ready_recive was low.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; write and read counters cleared.
  - Outputs: out_valid=0, out_i=out_q=0, out_first=out_last=0, drop_err=0, flag_ready_recive=1 on the first cycle after reset.
  - A reset mid-frame discards the frame; buffer contents are don't-care.
- Buffer: NFFT x 2*DATA_SIZE. Write is synchronous. Read is asynchronous (distributed RAM), feeding a registered output stage.
- Input accept: a sample is accepted when fft_complete && flag_ready_recive. It is written at wr_addr, and wr_addr increments.
  - fft_complete may have gaps; wr_addr holds during a gap.
- flag_ready_recive = 1 in IDLE and LOAD, 0 in CP and BODY.
- drop_err: fft_complete && !flag_ready_recive at any posedge sets drop_err. Only reset clears it.
- FSM:
  - IDLE -> LOAD on the first accepted sample (written at addr 0).
  - LOAD -> CP on the edge where sample NFFT-1 is accepted. rd_addr is loaded with NFFT-CP_LEN.
  - CP: each output handshake advances rd_addr. After sample index NFFT-1 is handed over, rd_addr wraps to 0 and state -> BODY.
  - BODY: emits indices 0..NFFT-1. On the out_last handshake, state -> IDLE.
- Output stage (AXI-style):
  - The output register loads when !out_valid || out_ready.
  - out_valid, out_i, out_q hold stable while out_valid && !out_ready.
- Latency:
  - First prefix sample (index NFFT-CP_LEN, out_first=1) is valid on the edge after the last input is accepted.
  - With out_ready held high, the symbol streams with no bubbles: NFFT+CP_LEN consecutive valid cycles.
- Frame boundary:
  - After the out_last handshake, flag_ready_recive=1 on the following cycle.
  - out_valid drops unless a new frame has completed. No overlap of frames; single buffer.
- Simultaneous events:
  - The last input acceptance and an output handshake cannot coincide; they are exclusive by state.
  - drop_err setting never changes the FSM.
- Widths: pure data movement; no arithmetic on samples. Counters are SIZE_BUFFER bits and wrap modulo NFFT.

Test Plan:
- SIZE_BUFFER=4, CP_LEN=4, out_ready=1; feed samples i=k, q=-k for k=0..15 contiguously.
  - Required: out_valid for 20 consecutive cycles starting 1 cycle after k=15.
  - I sequence 12,13,14,15,0..15.
  - out_first on the first 12; out_last on the final 15.
  - flag_ready_recive low during output, high on the next cycle.
- Same frame with fft_complete gaps (high 1 cycle, low 2 cycles).
  - Required: identical output sequence; wr_addr holds during gaps; no drop_err.
- Backpressure: out_ready toggled 1/0 every cycle, plus a 5-cycle low stretch mid-BODY.
  - Required: no sample lost or duplicated; held values stable while stalled; total 20 handshakes.
- Present fft_complete=1 during CP.
  - Required: drop_err=1 and stays 1; output sequence unaffected.
- Assert reset low mid-BODY, then release.
  - Required: state=0, out_valid=0, flag_ready_recive=1, drop_err=0.
  - A fresh frame then streams correctly.
- Defaults SIZE_BUFFER=8, CP_LEN=64, two back-to-back frames from myFFT.
  - Required: 320 samples per symbol; prefix starts at index 192; second frame accepted only after the first frame's out_last.
